// File: rtl/shift_reg_pe_sync_rsth.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_pe_sync_rsth
//  Brief    : DEPTH x WIDTH shift register with per-stage valid flags,
//             parallel load and fill count. Rotate mode is compiled in only
//             when SHIFT_REG_ROTATE_EN is defined; otherwise mode 11 holds.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_reg_pe_sync_rsth #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic [WIDTH-1:0]            d,
    input  logic                        d_vld,
    input  logic [WIDTH*DEPTH-1:0]      pd,
    output logic [WIDTH-1:0]            q,
    output logic                        vld,
    output logic [WIDTH*DEPTH-1:0]      pq,
    output logic [$clog2(DEPTH+1)-1:0]  fill
);

    localparam int         c_TOTAL_W     = WIDTH * DEPTH;
    localparam int         c_FILL_W      = $clog2(DEPTH + 1);
    localparam logic [1:0] c_MODE_HOLD   = 2'b00;
    localparam logic [1:0] c_MODE_SHIFT  = 2'b01;
    localparam logic [1:0] c_MODE_LOAD   = 2'b10;
`ifdef SHIFT_REG_ROTATE_EN
    localparam logic [1:0] c_MODE_ROTATE = 2'b11;
`endif

    // Stage k lives in r_data[k*WIDTH +: WIDTH], matching the pd/pq packing.
    logic [c_TOTAL_W-1:0] r_data;
    logic [DEPTH-1:0]     r_flag;
    logic [c_FILL_W-1:0]  r_fill;

    logic [c_TOTAL_W-1:0] w_data_next;
    logic [DEPTH-1:0]     w_flag_next;
    logic [c_FILL_W-1:0]  w_fill_next;

    always_comb begin
        w_data_next = r_data;
        w_flag_next = r_flag;
        if (en) begin
            case (mode)
                c_MODE_HOLD: begin
                    w_data_next = r_data;
                    w_flag_next = r_flag;
                end
                c_MODE_SHIFT: begin
                    w_data_next = {r_data[c_TOTAL_W-WIDTH-1:0], d};
                    w_flag_next = {r_flag[DEPTH-2:0], d_vld};
                end
                c_MODE_LOAD: begin
                    w_data_next = pd;
                    w_flag_next = {DEPTH{1'b1}};
                end
`ifdef SHIFT_REG_ROTATE_EN
                c_MODE_ROTATE: begin
                    w_data_next = {r_data[c_TOTAL_W-WIDTH-1:0],
                                   r_data[c_TOTAL_W-1 -: WIDTH]};
                    w_flag_next = {r_flag[DEPTH-2:0], r_flag[DEPTH-1]};
                end
`endif
                default: begin
                    w_data_next = r_data;
                    w_flag_next = r_flag;
                end
            endcase
        end
    end

    // Fill is the popcount of the next flags, registered with them so it
    // never glitches and always agrees with the stored flags.
    always_comb begin
        w_fill_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fill_next = w_fill_next + c_FILL_W'(w_flag_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_flag <= '0;
            r_fill <= '0;
        end else begin
            r_data <= w_data_next;
            r_flag <= w_flag_next;
            r_fill <= w_fill_next;
        end
    end

    assign q    = r_data[c_TOTAL_W-1 -: WIDTH];
    assign vld  = r_flag[DEPTH-1];
    assign pq   = r_data;
    assign fill = r_fill;

endmodule
`default_nettype wire

// File: doc/shift_reg_pe_sync_rsth.md
SHIFT_REG_PE_SYNC_RSTH -- requirements
Module: shift_reg_pe_sync_rsth

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of stages (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  stage update enable; 0 = hold all state.
REQ-006 SHALL have port mode  input  2  operation select: 00 hold, 01 shift, 10 parallel load, 11 rotate.
REQ-007 SHALL have port d  input  WIDTH  serial-in data word for stage 0.
REQ-008 SHALL have port d_vld  input  1  valid flag accompanying d.
REQ-009 SHALL have port pd  input  WIDTH*DEPTH  parallel-load data; stage k = pd[k*WIDTH +: WIDTH].
REQ-010 SHALL have port q  output  WIDTH  contents of stage DEPTH-1.
REQ-011 SHALL have port vld  output  1  valid flag of stage DEPTH-1.
REQ-012 SHALL have port pq  output  WIDTH*DEPTH  all stages, same packing as pd.
REQ-013 SHALL have port fill  output  $clog2(DEPTH+1)  count of stages whose valid flag is 1.

Function
REQ-014 SHALL hold DEPTH data stages of WIDTH bits, each with one valid flag.
REQ-015 SHALL drive q, vld, pq directly from stage registers (no combinational path from inputs).
REQ-016 SHALL, with en=0 and rst=0, hold all stages and flags regardless of mode.
REQ-017 SHALL, with en=1, mode=00, hold all stages and flags.
REQ-018 SHALL, with en=1, mode=01: stage0<=d, flag0<=d_vld; stage k<=stage k-1, flag k<=flag k-1 for k=1..DEPTH-1; stage DEPTH-1 old content discarded.
REQ-019 SHALL give shift latency of DEPTH enabled shift cycles from d sampled to q.
REQ-020 SHALL, with en=1, mode=10, load every stage from pd and set all flags to 1 in one cycle.
REQ-021 SHALL, with en=1, mode=11 (when rotate compiled in): stage0<=stage DEPTH-1, flag0<=flag DEPTH-1, others shift as REQ-018; d and d_vld ignored.
REQ-022 SHALL compute fill as popcount of all valid flags after each update; range 0..DEPTH, no wrap.
REQ-023 SHALL shift flag 0 into stages even when d_vld=0 (bubbles propagate; data still shifts).
REQ-024 SHALL be glitch-free on fill: fill registered or derived only from registered flags.

Reset
REQ-025 SHALL, when rst=1 at a rising clk edge, clear all stages to 0 and all flags to 0 (q=0, vld=0, pq=0, fill=0).
REQ-026 SHALL give rst priority over en and mode, including mid-shift and mid-rotate.
REQ-027 SHALL resume normal operation on the first rising edge with rst=0.
REQ-028 SHALL not be sensitive to rst between clock edges (no asynchronous path).

Configuration
REQ-029 SHALL use macro SHIFT_REG_ROTATE_EN to compile rotate mode in or out.
REQ-030 SHALL, with SHIFT_REG_ROTATE_EN defined, implement mode=11 per REQ-021.
REQ-031 SHALL, without SHIFT_REG_ROTATE_EN, treat mode=11 as hold (identical to mode=00); no rotate feedback path synthesised.

Verification (WIDTH=8, DEPTH=4)
REQ-032 SHALL cover reset: load pd=32'hDEADBEEF, then rst=1 one cycle with en=1, mode=01 -> next cycle pq=0, q=0, vld=0, fill=0.
REQ-033 SHALL cover shift latency: shift d=8'h11,22,33,44 with d_vld=1 -> q=8'h11, vld=1 after 4th edge; fill=1,2,3,4 on successive edges.
REQ-034 SHALL cover bubbles and saturation: from full, shift d_vld=0 four times -> fill 3,2,1,0; q follows the shifted-in data stream; fill never underflows.
REQ-035 SHALL cover enable/hold: load pd=32'h04030201, then en=0 with mode=01 for 3 cycles -> pq stays 32'h04030201, fill=4.
REQ-036 SHALL cover rotate (macro defined): load pd=32'h04030201, mode=11 one cycle -> pq=32'h03020104, fill=4; without macro same stimulus -> pq unchanged.
REQ-037 SHALL cover simultaneous events: rst=1 with mode=10 and pd=32'hFFFFFFFF -> pq=0, fill=0 (reset wins).
